// File: rtl/axi4_slave_pkg.sv
// Shared constants, state encodings and request-legality helper for the
// AXI4 burst slave RAM.
package axi4_slave_pkg;

  localparam logic [1:0] FIXED  = 2'b00;
  localparam logic [1:0] INCR   = 2'b01;
  localparam logic [1:0] WRAP   = 2'b10;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'b00,
    W_DATA = 2'b01,
    W_RESP = 2'b10
  } w_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_t;

  // A request is serviced normally only for FIXED/INCR bursts of full bus width.
  function automatic logic req_ok(input logic [1:0] burst,
                                  input logic [2:0] size,
                                  input logic [2:0] size_full);
    return ((burst == FIXED) || (burst == INCR)) && (size == size_full);
  endfunction

endpackage

// File: rtl/axi4_burst_slave_ram_if.sv
// AXI4 five-channel bundle with master and slave views.
interface axi4_burst_slave_ram_if #(
  parameter int ID_WIDTH       = 1,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32
);
  logic [ID_WIDTH-1:0]         awid;
  logic [AXI_ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]                  awlen;
  logic [2:0]                  awsize;
  logic [1:0]                  awburst;
  logic                        awvalid;
  logic                        awready;
  logic [AXI_DATA_WIDTH-1:0]   wdata;
  logic [AXI_DATA_WIDTH/8-1:0] wstrb;
  logic                        wlast;
  logic                        wvalid;
  logic                        wready;
  logic [ID_WIDTH-1:0]         bid;
  logic [1:0]                  bresp;
  logic                        bvalid;
  logic                        bready;
  logic [ID_WIDTH-1:0]         arid;
  logic [AXI_ADDR_WIDTH-1:0]   araddr;
  logic [7:0]                  arlen;
  logic [2:0]                  arsize;
  logic [1:0]                  arburst;
  logic                        arvalid;
  logic                        arready;
  logic [ID_WIDTH-1:0]         rid;
  logic [AXI_DATA_WIDTH-1:0]   rdata;
  logic [1:0]                  rresp;
  logic                        rlast;
  logic                        rvalid;
  logic                        rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
    input rid, rdata, rresp, rlast, rvalid, output rready
  );

  modport slave (
    input awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input arid, araddr, arlen, arsize, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );
endinterface

// File: rtl/axi4_slave_bram.sv
// Simple dual-port RAM: byte-enable write port, registered read port with
// read enable. Contents are never reset so the array maps onto block RAM.
module axi4_slave_bram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic [ADDR_WIDTH-1:0]   waddr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic                    re,
  input  logic [ADDR_WIDTH-1:0]   raddr,
  output logic [DATA_WIDTH-1:0]   rdata
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Byte-lane write; lanes with a cleared strobe keep their old contents.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DATA_WIDTH/8; i++) begin
      if (we && wstrb[i]) begin
        mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  // Read-first registered read; output holds while re is low.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[raddr];
    end
  end
endmodule

// File: rtl/axi4_burst_slave_ram.sv
// AXI4 slave with independent read and write burst engines in front of a
// block RAM. FIXED/INCR bursts only; anything else completes with SLVERR.
module axi4_burst_slave_ram
  import axi4_slave_pkg::*;
#(
  parameter int ID_WIDTH       = 1,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int MEM_ADDR_WIDTH = 8
) (
  input logic                   aclk,
  input logic                   aresetn,
  axi4_burst_slave_ram_if.slave bus
);
  localparam int         BYTES     = AXI_DATA_WIDTH / 8;
  localparam int         B         = $clog2(BYTES);
  localparam logic [2:0] SIZE_FULL = 3'(B);

  w_state_t                  w_state_r;
  logic                      awready_r, wready_r, bvalid_r, wbad_r, werr_r;
  logic [ID_WIDTH-1:0]       bid_r;
  logic [1:0]                bresp_r, wburst_r;
  logic [AXI_ADDR_WIDTH-1:0] waddr_r;
  logic [7:0]                wlen_r, wcnt_r;
  logic                      wlast_err_s, we_s;

  r_state_t                  r_state_r;
  logic                      arready_r, rvalid_r, rlast_r, rbad_r;
  logic [ID_WIDTH-1:0]       rid_r;
  logic [1:0]                rresp_r, rburst_r;
  logic [AXI_ADDR_WIDTH-1:0] raddr_r, raddr_next_s;
  logic [7:0]                rlen_r, rcnt_r;
  logic                      re_s;
  logic [MEM_ADDR_WIDTH-1:0] rd_index_s;
  logic [AXI_DATA_WIDTH-1:0] ram_dout_s;

  // Write-beat decode: wlast consistency and memory write enable.
  always_comb begin
    wlast_err_s = (bus.wlast != (wcnt_r == wlen_r));
    we_s        = (w_state_r == W_DATA) && wready_r && bus.wvalid && !wbad_r;
  end

  // Write FSM: latch AW, count W beats, hold B until accepted.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state_r <= W_IDLE;
      awready_r <= 1'b0;
      wready_r  <= 1'b0;
      bvalid_r  <= 1'b0;
      bid_r     <= '0;
      bresp_r   <= OKAY;
      waddr_r   <= '0;
      wlen_r    <= 8'd0;
      wcnt_r    <= 8'd0;
      wburst_r  <= FIXED;
      wbad_r    <= 1'b0;
      werr_r    <= 1'b0;
    end else begin
      case (w_state_r)
        W_IDLE: begin
          if (awready_r && bus.awvalid) begin
            bid_r     <= bus.awid;
            waddr_r   <= bus.awaddr;
            wlen_r    <= bus.awlen;
            wburst_r  <= bus.awburst;
            wbad_r    <= !req_ok(bus.awburst, bus.awsize, SIZE_FULL);
            werr_r    <= 1'b0;
            wcnt_r    <= 8'd0;
            awready_r <= 1'b0;
            wready_r  <= 1'b1;
            w_state_r <= W_DATA;
          end else begin
            awready_r <= 1'b1;
          end
        end
        W_DATA: begin
          if (wready_r && bus.wvalid) begin
            if (wcnt_r == wlen_r) begin
              wready_r  <= 1'b0;
              bvalid_r  <= 1'b1;
              bresp_r   <= (wbad_r || werr_r || wlast_err_s) ? SLVERR : OKAY;
              w_state_r <= W_RESP;
            end else begin
              wcnt_r  <= wcnt_r + 8'd1;
              werr_r  <= werr_r || wlast_err_s;
              waddr_r <= (wburst_r == INCR) ? waddr_r + AXI_ADDR_WIDTH'(BYTES) : waddr_r;
            end
          end
        end
        W_RESP: begin
          if (bus.bready) begin
            bvalid_r  <= 1'b0;
            awready_r <= 1'b1;
            w_state_r <= W_IDLE;
          end
        end
        default: begin
          w_state_r <= W_IDLE;
          awready_r <= 1'b0;
          wready_r  <= 1'b0;
          bvalid_r  <= 1'b0;
        end
      endcase
    end
  end

  // Read port steering: first beat from AR, later beats on each R handshake.
  always_comb begin
    raddr_next_s = (rburst_r == INCR) ? raddr_r + AXI_ADDR_WIDTH'(BYTES) : raddr_r;
    re_s         = 1'b0;
    rd_index_s   = raddr_r[MEM_ADDR_WIDTH+B-1:B];
    if ((r_state_r == R_IDLE) && arready_r && bus.arvalid) begin
      re_s       = 1'b1;
      rd_index_s = bus.araddr[MEM_ADDR_WIDTH+B-1:B];
    end else if ((r_state_r == R_DATA) && rvalid_r && bus.rready && !rlast_r) begin
      re_s       = 1'b1;
      rd_index_s = raddr_next_s[MEM_ADDR_WIDTH+B-1:B];
    end else begin
      re_s       = 1'b0;
    end
  end

  // Read FSM: latch AR, present one beat per handshake, hold while stalled.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state_r <= R_IDLE;
      arready_r <= 1'b0;
      rvalid_r  <= 1'b0;
      rlast_r   <= 1'b0;
      rid_r     <= '0;
      rresp_r   <= OKAY;
      raddr_r   <= '0;
      rlen_r    <= 8'd0;
      rcnt_r    <= 8'd0;
      rburst_r  <= FIXED;
      rbad_r    <= 1'b0;
    end else begin
      case (r_state_r)
        R_IDLE: begin
          if (arready_r && bus.arvalid) begin
            rid_r     <= bus.arid;
            raddr_r   <= bus.araddr;
            rlen_r    <= bus.arlen;
            rburst_r  <= bus.arburst;
            rbad_r    <= !req_ok(bus.arburst, bus.arsize, SIZE_FULL);
            rresp_r   <= req_ok(bus.arburst, bus.arsize, SIZE_FULL) ? OKAY : SLVERR;
            rcnt_r    <= 8'd0;
            rlast_r   <= (bus.arlen == 8'd0);
            rvalid_r  <= 1'b1;
            arready_r <= 1'b0;
            r_state_r <= R_DATA;
          end else begin
            arready_r <= 1'b1;
          end
        end
        R_DATA: begin
          if (rvalid_r && bus.rready) begin
            if (rlast_r) begin
              rvalid_r  <= 1'b0;
              rlast_r   <= 1'b0;
              arready_r <= 1'b1;
              r_state_r <= R_IDLE;
            end else begin
              rcnt_r  <= rcnt_r + 8'd1;
              rlast_r <= ((rcnt_r + 8'd1) == rlen_r);
              raddr_r <= raddr_next_s;
            end
          end
        end
        default: begin
          r_state_r <= R_IDLE;
          arready_r <= 1'b0;
          rvalid_r  <= 1'b0;
          rlast_r   <= 1'b0;
        end
      endcase
    end
  end

  axi4_slave_bram #(
    .DATA_WIDTH(AXI_DATA_WIDTH),
    .ADDR_WIDTH(MEM_ADDR_WIDTH)
  ) u_bram (
    .clk  (aclk),
    .we   (we_s),
    .wstrb(bus.wstrb),
    .waddr(waddr_r[MEM_ADDR_WIDTH+B-1:B]),
    .wdata(bus.wdata),
    .re   (re_s),
    .raddr(rd_index_s),
    .rdata(ram_dout_s)
  );

  assign bus.awready = awready_r;
  assign bus.wready  = wready_r;
  assign bus.bvalid  = bvalid_r;
  assign bus.bid     = bid_r;
  assign bus.bresp   = bresp_r;
  assign bus.arready = arready_r;
  assign bus.rvalid  = rvalid_r;
  assign bus.rlast   = rlast_r;
  assign bus.rid     = rid_r;
  assign bus.rresp   = rresp_r;
  // RAM output register is not reset; gate it so idle, reset and error beats read 0.
  assign bus.rdata   = (rvalid_r && !rbad_r) ? ram_dout_s : '0;
endmodule

// File: doc/axi4_burst_slave_ram.md
AXI4_BURST_SLAVE_RAM -- requirements
Module: axi4_burst_slave_ram

Interface
REQ-001 Parameter ID_WIDTH, default 1, width of all ID fields.
REQ-002 Parameter AXI_DATA_WIDTH, default 32, data bus width; legal values are 32 and 64.
REQ-003 Parameter AXI_ADDR_WIDTH, default 32, byte address width.
REQ-004 Parameter MEM_ADDR_WIDTH, default 8, log2 of memory depth in data words.
REQ-005 aclk, input, 1: single clock; all logic SHALL be rising-edge aclk.
REQ-006 aresetn, input, 1: reset, asynchronous and active-low.
REQ-007 Write address channel SHALL have these ports:
- Inputs: awid[ID_WIDTH], awaddr[AXI_ADDR_WIDTH], awlen[8], awsize[3], awburst[2], awvalid.
- Output: awready.
REQ-008 Write data channel SHALL have these ports:
- Inputs: wdata[AXI_DATA_WIDTH], wstrb[AXI_DATA_WIDTH/8], wlast, wvalid.
- Output: wready.
REQ-009 Write response channel SHALL have these ports:
- Outputs: bid[ID_WIDTH], bresp[2], bvalid.
- Input: bready.
REQ-010 Read address channel SHALL have these ports:
- Inputs: arid[ID_WIDTH], araddr[AXI_ADDR_WIDTH], arlen[8], arsize[3], arburst[2], arvalid.
- Output: arready.
REQ-011 Read data channel SHALL have these ports:
- Outputs: rid[ID_WIDTH], rdata[AXI_DATA_WIDTH], rresp[2], rlast, rvalid.
- Input: rready.

Function
REQ-012 Write FSM states SHALL be W_IDLE, W_DATA, W_RESP:
- awready=1 only in W_IDLE.
- AW handshake latches id, addr, len and burst, then moves to W_DATA.
REQ-013 In W_DATA, wready SHALL be 1, and each wvalid&&wready beat SHALL write the bytes enabled by wstrb.
- Target word index: addr[MEM_ADDR_WIDTH+B-1:B], where B = log2(AXI_DATA_WIDTH/8).
REQ-014 The write address SHALL advance per beat as follows:
- INCR (01): add AXI_DATA_WIDTH/8 bytes.
- FIXED (00): hold.
- Index wraps modulo 2^MEM_ADDR_WIDTH; addresses above the memory alias.
REQ-015 The beat counter SHALL end the burst on beat number awlen (awlen+1 beats), moving to W_RESP on the next edge.
- An early or missing wlast SHALL NOT end the burst.
- Any beat whose wlast disagrees with (count==awlen) SHALL set bresp to SLVERR.
REQ-016 In W_RESP, bvalid=1 and bid=latched awid, held stable until bready.
- bvalid&&bready SHALL return the FSM to W_IDLE.
- awready SHALL re-assert no earlier than the cycle after the B handshake.
REQ-017 Read FSM states SHALL be R_IDLE, R_DATA:
- arready=1 only in R_IDLE.
- AR handshake latches id, addr, len and burst.
- rvalid SHALL assert on the next cycle with rdata = mem[start index] (one-cycle latency).
REQ-018 rdata, rresp, rlast and rid SHALL hold stable while rvalid&&!rready.
- On rvalid&&rready, the next beat SHALL be presented the following cycle, giving one beat per cycle with rready held high.
REQ-019 rlast SHALL be 1 exactly on beat number arlen.
- The handshake of the last beat SHALL return the FSM to R_IDLE.
- arready SHALL re-assert on the cycle after that handshake.
REQ-020 awburst/arburst WRAP (10) or reserved (11), or awsize/arsize not equal to log2(AXI_DATA_WIDTH/8), SHALL still complete len+1 beats, but:
- Writes are discarded.
- Read data is 0.
- bresp/rresp = SLVERR (10).
- Otherwise OKAY (00).
REQ-021 Read and write channels SHALL operate independently and concurrently, with one outstanding transaction per direction.
- Same-cycle read and write to the same word: the read returns old data.

Reset
REQ-022 While aresetn=0, all outputs SHALL be 0: awready, wready, bvalid, arready, rvalid, rlast, bresp, rresp, bid, rid, rdata.
- Both FSMs SHALL be idle.
REQ-023 Reset asserted mid-burst SHALL abort both transactions with no response issued.
- Memory contents SHALL NOT be reset or initialised.
REQ-024 awready and arready SHALL assert on the first aclk edge after reset release.

Structure
REQ-025 Package axi4_slave_pkg SHALL hold:
- Burst type constants FIXED/INCR/WRAP.
- Response constants OKAY/SLVERR.
- Write and read state enums.
REQ-026 Storage SHALL be sub-module axi4_slave_bram: single-clock simple dual-port RAM with byte-enable write and registered read with read-enable, inferable as block RAM.

Verification
REQ-027 INCR write, then read back:
- AW addr 0x10, len 3, INCR, data 0xA0..0xA3, strb all ones, followed by AR of the same burst.
- Required: rdata A0,A1,A2,A3; rlast on the 4th beat; bresp = rresp = 00; bid/rid echo their IDs.
REQ-028 Byte strobes: write 0xFFFFFFFF, then a single beat 0x12345678 with strb 0101 to the same address; read SHALL return 0xFF34FF78.
REQ-029 FIXED write: len 2 to addr 0x20 with 1, 2, 3; a single read SHALL return 3, and addr 0x24 SHALL be unchanged.
REQ-030 Backpressure and throughput:
- Read len 7 with rready toggling 1010...: each beat held stable while stalled; all 8 beats returned in order.
- With rready=1 throughout: 8 beats in 8 consecutive cycles.
REQ-031 Error responses:
- WRAP read: 0s with rresp=10.
- Write with wlast on beat 1 of len 3: 4 beats accepted, bresp=10.
REQ-032 Reset mid-burst and address wrap:
- Deassert aresetn during beat 2 of a len 5 read: rvalid=0 immediately; after release, arready=1 on the next edge and a new read succeeds.
- INCR write at the last memory word with len 1: the second beat lands in word 0.
